// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback path.
//   NUM_REGS / REG_IDX_W : register file geometry (8 registers, 3-bit index)
//   SIZE_*               : data_size encodings consumed by the register file
//   wb_req_t             : one writeback request (destination, size, data)
package wb_pkg;

  localparam int unsigned NUM_REGS  = 8;
  localparam int unsigned REG_IDX_W = 3;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rdest;
    logic [1:0]           size;
    logic [31:0]          data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests used to buffer load results.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data : write an entry (ignored when full)
//   pop         : retire the head entry (ignored when empty)
//   head        : current head entry, valid while !empty
//   full, empty : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wb_req_t     mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; occupancy is defined purely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/writeback_scheduler.sv
// Shares the register file's single write port between the ALU and the load
// unit, and keeps a per-register pending scoreboard so issue stalls on RAW,
// and WAW hazards against in-flight writes.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   issue_valid/issue_writes  : instruction presented / it writes issue_rdest
//   issue_rsrc1/2, issue_rdest: register indices of the presented instruction
//   issue_stall               : combinational hazard, instruction held
//   alu_valid/alu_ready       : ALU writeback handshake (ready = granted)
//   alu_rdest/size/data       : ALU writeback payload
//   ld_valid/ld_ready         : load writeback handshake (ready = FIFO not full)
//   ld_rdest/size/data        : load writeback payload
//   rf_write_enable, rf_rdest, rf_data_size, rf_write_data : registered
//                               register-file write port
// Loads normally win arbitration; after MAX_WAIT consecutive refused cycles
// the ALU is granted regardless.
module writeback_scheduler
  import wb_pkg::*;
#(
  parameter int unsigned LD_DEPTH = 4,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 issue_valid,
  input  logic                 issue_writes,
  input  logic [REG_IDX_W-1:0] issue_rsrc1,
  input  logic [REG_IDX_W-1:0] issue_rsrc2,
  input  logic [REG_IDX_W-1:0] issue_rdest,
  output logic                 issue_stall,

  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_IDX_W-1:0] alu_rdest,
  input  logic [1:0]           alu_size,
  input  logic [31:0]          alu_data,

  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [REG_IDX_W-1:0] ld_rdest,
  input  logic [1:0]           ld_size,
  input  logic [31:0]          ld_data,

  output logic                 rf_write_enable,
  output logic [REG_IDX_W-1:0] rf_rdest,
  output logic [1:0]           rf_data_size,
  output logic [31:0]          rf_write_data
);

  localparam int unsigned         WAIT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0]   WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  logic [NUM_REGS-1:0] pending;
  logic [WAIT_W-1:0]   alu_wait;

  wb_req_t ld_req;
  wb_req_t ld_head;
  wb_req_t alu_req;
  logic    fifo_full;
  logic    fifo_empty;
  logic    ld_push;
  logic    grant_alu;
  logic    grant_ld;
  logic    issue_fire;

  // ---------------------------------------------------------------- scoreboard
  // No bypass: a register whose write is on the rf_* port this cycle still
  // reads as pending, so the dependent issues one cycle later.
  assign issue_stall = issue_valid &&
                       (pending[issue_rsrc1] || pending[issue_rsrc2] ||
                        (issue_writes && pending[issue_rdest]));

  assign issue_fire = issue_valid && !issue_stall && issue_writes;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      // Set and clear never hit the same index: issue stalls on a pending rdest.
      if (rf_write_enable) pending[rf_rdest]    <= 1'b0;
      if (issue_fire)      pending[issue_rdest] <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- load FIFO
  assign ld_req   = '{rdest: ld_rdest, size: ld_size, data: ld_data};
  assign alu_req  = '{rdest: alu_rdest, size: alu_size, data: alu_data};
  assign ld_ready = !fifo_full;
  assign ld_push  = ld_valid && ld_ready;

  wb_fifo #(
    .DEPTH (LD_DEPTH)
  ) u_ld_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ld_push),
    .push_data (ld_req),
    .pop       (grant_ld),
    .head      (ld_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---------------------------------------------------------------- arbitration
  always_comb begin
    grant_alu = 1'b0;
    grant_ld  = 1'b0;
    if (alu_valid && (fifo_empty || alu_wait == WAIT_LIMIT)) begin
      grant_alu = 1'b1;
    end else if (!fifo_empty) begin
      grant_ld = 1'b1;
    end
  end

  assign alu_ready = grant_alu;

  always_ff @(posedge clk) begin
    if (rst || !alu_valid || grant_alu) begin
      alu_wait <= '0;
    end else if (alu_wait != WAIT_LIMIT) begin
      alu_wait <= alu_wait + WAIT_W'(1);
    end
  end

  // ---------------------------------------------------------------- output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_write_enable <= 1'b0;
      rf_rdest        <= '0;
      rf_data_size    <= '0;
      rf_write_data   <= '0;
    end else if (grant_alu) begin
      rf_write_enable <= 1'b1;
      rf_rdest        <= alu_req.rdest;
      rf_data_size    <= alu_req.size;
      rf_write_data   <= alu_req.data;
    end else if (grant_ld) begin
      rf_write_enable <= 1'b1;
      rf_rdest        <= ld_head.rdest;
      rf_data_size    <= ld_head.size;
      rf_write_data   <= ld_head.data;
    end else begin
      rf_write_enable <= 1'b0;
    end
  end

endmodule
